cpuif_arbiter: RTL

Shares one register-block CPU interface (`cpuif_req`/`cpuif_rd_ack`/`cpuif_wr_ack` style) between `N_REQ` bus masters, e.g. an APB front end and an internal sequencer. It sits between the masters and the register block's address-decode stage. It arbitrates round-robin, issues exactly one transaction at a time, and routes the response back to the granted master.

---
 rtl/cpuif_arb_pkg.sv | 10 +
 rtl/cpuif_arbiter_if.sv | 41 ++++
 rtl/cpuif_arbiter_rr.sv | 22 ++
 rtl/cpuif_arbiter.sv | 94 +++++++++
 4 files changed

// File: rtl/cpuif_arb_pkg.sv
// cpuif_arb_pkg: shared types for the CPU-interface arbiter (FSM states, captured response)
package cpuif_arb_pkg;
  localparam int CPUIF_ARB_MAX_DW = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} cpuif_arb_state_e;
  typedef struct packed {
    logic                        ack;
    logic [CPUIF_ARB_MAX_DW-1:0] rd_data;
    logic                        err;
  } cpuif_arb_rsp_t;
endpackage

// File: rtl/cpuif_arbiter_if.sv
// cpuif_arbiter_if: requester-side and register-block-side signals of the shared CPU interface
interface cpuif_arbiter_if #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic [N_REQ-1:0]                 req_valid;
  logic [N_REQ-1:0]                 req_is_wr;
  logic [N_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_wr_data;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_wr_biten;
  logic [N_REQ-1:0]                 req_ack;
  logic [DATA_WIDTH-1:0]            req_rd_data;
  logic                             req_err;
  logic                             cpuif_req;
  logic                             cpuif_req_is_wr;
  logic [ADDR_WIDTH-1:0]            cpuif_addr;
  logic [DATA_WIDTH-1:0]            cpuif_wr_data;
  logic [DATA_WIDTH-1:0]            cpuif_wr_biten;
  logic                             cpuif_rd_ack;
  logic [DATA_WIDTH-1:0]            cpuif_rd_data;
  logic                             cpuif_rd_err;
  logic                             cpuif_wr_ack;
  logic                             cpuif_wr_err;
  logic                             busy;
  logic [$clog2(N_REQ)-1:0]         grant_idx;
  modport slave (
    input  req_valid, req_is_wr, req_addr, req_wr_data, req_wr_biten,
    output req_ack, req_rd_data, req_err,
    output cpuif_req, cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_biten,
    input  cpuif_rd_ack, cpuif_rd_data, cpuif_rd_err, cpuif_wr_ack, cpuif_wr_err,
    output busy, grant_idx
  );
  modport master (
    output req_valid, req_is_wr, req_addr, req_wr_data, req_wr_biten,
    input  req_ack, req_rd_data, req_err,
    input  cpuif_req, cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_biten,
    output cpuif_rd_ack, cpuif_rd_data, cpuif_rd_err, cpuif_wr_ack, cpuif_wr_err,
    input  busy, grant_idx
  );
endinterface

// File: rtl/cpuif_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker, search starts at last_grant+1 and wraps
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic                     gnt_valid,
  output logic [$clog2(N_REQ)-1:0] gnt_idx
);
  localparam int IW = $clog2(N_REQ);
  // scan farthest offset first so the closest requester after last_grant wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req[IW'((int'(last_grant) + i) % N_REQ)]) begin
        gnt_valid = 1'b1;
        gnt_idx = IW'((int'(last_grant) + i) % N_REQ);
      end
    end
  end
endmodule

// File: rtl/cpuif_arbiter.sv
// cpuif_arbiter: round-robin sharing of one register-block CPU interface; CPUIF_ARB_TIMEOUT_EN adds a WAIT watchdog
module cpuif_arbiter
  import cpuif_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            rst_n,
  cpuif_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  cpuif_arb_state_e      state_q, state_d;
  logic [IW-1:0]         last_grant_q, grant_idx_q, gnt_idx;
  logic                  gnt_valid, ack_in, tmo_hit, capture;
  logic                  is_wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_biten_q;
  cpuif_arb_rsp_t        rsp_q, rsp_d;
  if (N_REQ < 2 || DATA_WIDTH > CPUIF_ARB_MAX_DW || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("cpuif_arbiter: need N_REQ>=2, DATA_WIDTH<=32, TIMEOUT_CYCLES>=1");
  end
  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (bus.req_valid),
    .last_grant(last_grant_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );
`ifdef CPUIF_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  // watchdog counts WAIT cycles, cleared in every other state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo_q <= '0;
    else tmo_q <= (state_q == WAIT) ? tmo_q + 1'b1 : '0;
  assign tmo_hit = (state_q == WAIT) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif
  // next state and response capture; a real ack takes priority over the watchdog
  always_comb begin
    ack_in = bus.cpuif_rd_ack | bus.cpuif_wr_ack;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = gnt_valid ? ISSUE : IDLE;
      ISSUE:   state_d = ack_in ? RESP : WAIT;
      WAIT:    state_d = (ack_in || tmo_hit) ? RESP : WAIT;
      default: state_d = IDLE;
    endcase
    capture = (state_q == ISSUE || state_q == WAIT) && state_d == RESP;
    rsp_d = '0;
    rsp_d.ack = 1'b1;
    rsp_d.rd_data[DATA_WIDTH-1:0] = (ack_in && !is_wr_q) ? bus.cpuif_rd_data : '0;
    rsp_d.err = ack_in ? (bus.cpuif_rd_err | bus.cpuif_wr_err) : 1'b1;
  end
  // state and response registers; response is zero outside RESP
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rsp_q <= '0;
    end else begin
      state_q <= state_d;
      rsp_q <= capture ? rsp_d : '0;
    end
  // latch the winner's payload and index on grant
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_grant_q <= IW'(N_REQ - 1);
      grant_idx_q <= '0;
      is_wr_q <= 1'b0;
      addr_q <= '0;
      wr_data_q <= '0;
      wr_biten_q <= '0;
    end else if (state_q == IDLE && gnt_valid) begin
      last_grant_q <= gnt_idx;
      grant_idx_q <= gnt_idx;
      is_wr_q <= bus.req_is_wr[gnt_idx];
      addr_q <= bus.req_addr[gnt_idx];
      wr_data_q <= bus.req_wr_data[gnt_idx];
      wr_biten_q <= bus.req_wr_biten[gnt_idx];
    end
  assign bus.cpuif_req       = state_q == ISSUE;
  assign bus.cpuif_req_is_wr = is_wr_q;
  assign bus.cpuif_addr      = addr_q;
  assign bus.cpuif_wr_data   = wr_data_q;
  assign bus.cpuif_wr_biten  = wr_biten_q;
  assign bus.req_ack         = rsp_q.ack ? N_REQ'(1) << grant_idx_q : '0;
  assign bus.req_rd_data     = rsp_q.rd_data[DATA_WIDTH-1:0];
  assign bus.req_err         = rsp_q.err;
  assign bus.busy            = state_q != IDLE;
  assign bus.grant_idx       = grant_idx_q;
endmodule
